word_serializer: RTL and testbench
==================================

Name: word_serializer

Overview:
- Reader-side counterpart to the single-bit storage flop: accepts a parallel WIDTH-bit word over a valid/ready handshake and plays it out one bit per accepted beat.
- Bits go out on a complementary q/qbar pair, with first/last framing flags.
- Sits between register/datapath storage and any bit-serial consumer (debug scan-out, serial link, bit-serial ALU).

Parameters:
- WIDTH, 8, bits per word; legal range 1..64.
- LSB_FIRST, 1, 1 = bit 0 shifted out first; 0 = bit WIDTH-1 first.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- in_valid  input  1  in_data holds a word to load.
- in_ready  output  1  serializer can accept a word this cycle.
- in_data  input  WIDTH  parallel word.
- out_valid  output  1  out_q/out_qbar hold a valid bit.
- out_ready  input  1  consumer accepts the current bit.
- out_q  output  1  current serial bit.
- out_qbar  output  1  always the complement of out_q, including during reset.
- out_first  output  1  current bit is the first of its word.
- out_last  output  1  current bit is the last of its word.
- busy  output  1  a word is loaded and not yet fully drained.

Behaviour:
- Reset (reset==0, asynchronous, takes effect immediately, no clock needed):
  - State = IDLE; shift register and bit counter cleared.
  - out_valid=0, out_q=0, out_qbar=1, out_first=0, out_last=0, busy=0.
  - in_ready=0 while reset is asserted. It rises on deassertion, with no clock edge required.
- States: IDLE, SHIFT.
- IDLE:
  - in_ready=1, out_valid=0.
  - On a clock edge with in_valid&&in_ready: latch in_data into the shift register, set count=0, go to SHIFT.
  - The first bit is valid on the next cycle (load-to-first-bit latency = 1 clock).
- SHIFT:
  - out_valid=1, busy=1.
  - out_q = shreg[0] if LSB_FIRST, else shreg[WIDTH-1].
  - out_first = (count==0); out_last = (count==WIDTH-1).
- Stall: out_valid&&!out_ready holds out_q, out_qbar, out_first, out_last and count stable for any number of cycles.
- Beat accepted (out_valid&&out_ready at an edge):
  - If not last: shift by one toward the output end, count+=1.
  - If last and in_valid: reload from in_data, count=0, stay in SHIFT. This is a back-to-back word with no bubble.
  - If last and !in_valid: go to IDLE.
- in_ready = (state==IDLE) || (out_last && out_ready). The combinational path from out_ready to in_ready is intentional and documented.
- in_valid while in SHIFT and not at a last-beat acceptance: ignored, no capture. The upstream holds the word (standard valid/ready rules).
- Counter width = max(1, $clog2(WIDTH)). count never exceeds WIDTH-1; no wrap beyond it.
- WIDTH==1: out_first and out_last are both 1 on every beat.
- Reset asserted mid-word: the word is discarded; no partial resume after deassertion.
- out_qbar is registered alongside out_q (or derived as ~out_q). It is never equal to out_q.

Decomposition:
- Package ctrino_ser_pkg:
  - typedef enum logic {SER_IDLE, SER_SHIFT} ser_state_t.
  - function ser_cnt_w(width) returning max(1, $clog2(width)).
- Sub-module bit_counter (parameter WIDTH):
  - inputs: clear, advance; outputs: count, at_first, at_last.
  - clk and the same active-low async reset.
  - Reused by future bit-serial blocks.

Test Plan:
- Reset check: reset=0 with random inputs -> out_valid=0, out_q=0, out_qbar=1, in_ready=0. Deassert -> in_ready=1, busy=0.
- Basic word, LSB_FIRST=1, WIDTH=8, in_data=8'hA5, out_ready=1 -> out_q sequence 1,0,1,0,0,1,0,1 over 8 cycles starting 1 clock after load. out_first on beat 0 only, out_last on beat 7 only, then IDLE.
- Stall: same word, out_ready=0 for 3 cycles at beat 3 -> out_q=0 held, count held, no bits lost. Total drain = 11 cycles.
- Back-to-back: 8'hFF then 8'h00 with in_valid held -> 16 consecutive valid beats (eight 1s then eight 0s). in_ready=1 exactly on the last beat of word 1; no idle cycle between words.
- MSB_FIRST: LSB_FIRST=0, in_data=8'h81 -> sequence 1,0,0,0,0,0,0,1. Confirm with 8'h80 -> 1 first, then seven 0s.
- Reset mid-word: reset=0 at beat 4 of 8'hA5 -> outputs go to reset values the same cycle. After release, a new load of 8'h3C drains cleanly from bit 0 with out_first=1.

Source files
------------

// File: rtl/word_serializer_pkg.sv
// ============================================================================
// Module : ctrino_ser_pkg
// Shared state encoding and sizing helper for the bit-serial blocks.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package ctrino_ser_pkg;

  typedef enum logic {
    SER_IDLE  = 1'b0,
    SER_SHIFT = 1'b1
  } ser_state_t;

  // Bit-index counter width; a 1-bit word still gets a 1-bit counter.
  function automatic int ser_cnt_w(input int width);
    int w;
    w = $clog2(width);
    return (w < 1) ? 1 : w;
  endfunction

endpackage : ctrino_ser_pkg

`default_nettype wire

// File: rtl/word_serializer_bit_counter.sv
// ============================================================================
// Module : bit_counter
// Bit position counter for a WIDTH-bit serial word, saturating at WIDTH-1.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module bit_counter
  import ctrino_ser_pkg::*;
#(
  parameter int WIDTH = 8,
  localparam int CW   = ser_cnt_w(WIDTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic          advance,
  output logic [CW-1:0] count,
  output logic          at_first,
  output logic          at_last
);

  localparam logic [CW-1:0] c_LAST = CW'(WIDTH - 1);

  logic [CW-1:0] r_count;
  logic          w_at_last;

  assign w_at_last = (r_count == c_LAST);

  // Clear wins over advance; the count never moves past the last bit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
    end else if (clear) begin
      r_count <= '0;
    end else if (advance && !w_at_last) begin
      r_count <= r_count + CW'(1);
    end
  end

  assign count    = r_count;
  assign at_first = (r_count == '0);
  assign at_last  = w_at_last;

endmodule : bit_counter

`default_nettype wire

// File: rtl/word_serializer.sv
// ============================================================================
// Module : word_serializer
// Loads a parallel word over valid/ready and plays it out one bit per beat.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module word_serializer
  import ctrino_ser_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int LSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_q,
  output logic             out_qbar,
  output logic             out_first,
  output logic             out_last,
  output logic             busy
);

  localparam int CW = ser_cnt_w(WIDTH);

  ser_state_t       r_state;
  ser_state_t       w_next_state;
  logic [WIDTH-1:0] r_shreg;
  logic [WIDTH-1:0] w_shifted;
  logic             w_bit;
  logic [CW-1:0]    w_count;
  logic             w_at_first;
  logic             w_at_last;
  logic             w_shift_st;
  logic             w_beat;
  logic             w_last_beat;
  logic             w_load;
  logic             w_in_ready;

  generate
    if (LSB_FIRST != 0) begin : g_lsb_first
      assign w_bit     = r_shreg[0];
      assign w_shifted = r_shreg >> 1;
    end else begin : g_msb_first
      assign w_bit     = r_shreg[WIDTH-1];
      assign w_shifted = r_shreg << 1;
    end
  endgenerate

  assign w_shift_st  = (r_state == SER_SHIFT);
  assign w_beat      = w_shift_st && out_ready;
  assign w_last_beat = w_beat && w_at_last;
  // out_ready reaches in_ready combinationally so a new word can follow the
  // last bit with no bubble; reset holds in_ready low without a clock.
  assign w_in_ready  = reset && (!w_shift_st || (w_at_last && out_ready));
  assign w_load      = in_valid && w_in_ready;

  bit_counter #(
    .WIDTH (WIDTH)
  ) u_bit_counter (
    .clk      (clk),
    .reset    (reset),
    .clear    (w_load || w_last_beat),
    .advance  (w_beat),
    .count    (w_count),
    .at_first (w_at_first),
    .at_last  (w_at_last)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= SER_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_shreg <= '0;
    end else if (w_load) begin
      r_shreg <= in_data;
    end else if (w_beat) begin
      r_shreg <= w_shifted;
    end
  end

  always_comb begin
    w_next_state = r_state;
    in_ready     = w_in_ready;
    out_valid    = 1'b0;
    out_first    = 1'b0;
    out_last     = 1'b0;
    busy         = 1'b0;
    case (r_state)
      SER_IDLE: begin
        if (w_load) begin
          w_next_state = SER_SHIFT;
        end
      end
      SER_SHIFT: begin
        out_valid = 1'b1;
        busy      = 1'b1;
        out_first = w_at_first;
        out_last  = w_at_last;
        if (w_last_beat && !in_valid) begin
          w_next_state = SER_IDLE;
        end
      end
      default: begin
        w_next_state = SER_IDLE;
      end
    endcase
  end

  // Shift register clears on reset, so out_q/out_qbar are 0/1 in reset too.
  assign out_q    = w_bit;
  assign out_qbar = ~w_bit;

  logic [CW-1:0] w_unused_count;
  assign w_unused_count = w_count;

endmodule : word_serializer

`default_nettype wire

// File: tb/tb_word_serializer.sv
// ============================================================================
// Module : tb_word_serializer
// Directed self-checking bench for word_serializer (LSB, MSB and 1-bit cases).
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_word_serializer;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  // LSB-first, 8-bit
  logic       a_in_valid, a_in_ready, a_out_valid, a_out_ready;
  logic       a_q, a_qbar, a_first, a_last, a_busy;
  logic [7:0] a_in_data;
  // MSB-first, 8-bit
  logic       b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic       b_q, b_qbar, b_first, b_last, b_busy;
  logic [7:0] b_in_data;
  // 1-bit word
  logic       c_in_valid, c_in_ready, c_out_valid, c_out_ready;
  logic       c_q, c_qbar, c_first, c_last, c_busy;
  logic [0:0] c_in_data;

  word_serializer #(.WIDTH(8), .LSB_FIRST(1)) u_dut_a (
    .clk(clk), .reset(reset), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_data(a_in_data), .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_q(a_q), .out_qbar(a_qbar), .out_first(a_first), .out_last(a_last),
    .busy(a_busy)
  );

  word_serializer #(.WIDTH(8), .LSB_FIRST(0)) u_dut_b (
    .clk(clk), .reset(reset), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_data(b_in_data), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_q(b_q), .out_qbar(b_qbar), .out_first(b_first), .out_last(b_last),
    .busy(b_busy)
  );

  word_serializer #(.WIDTH(1), .LSB_FIRST(1)) u_dut_c (
    .clk(clk), .reset(reset), .in_valid(c_in_valid), .in_ready(c_in_ready),
    .in_data(c_in_data), .out_valid(c_out_valid), .out_ready(c_out_ready),
    .out_q(c_q), .out_qbar(c_qbar), .out_first(c_first), .out_last(c_last),
    .busy(c_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    a_in_valid = 1'($urandom); a_in_data = 8'($urandom); a_out_ready = 1'($urandom);
    b_in_valid = 1'($urandom); b_in_data = 8'($urandom); b_out_ready = 1'($urandom);
    c_in_valid = 1'($urandom); c_in_data = 1'($urandom); c_out_ready = 1'($urandom);
    #3;
    total++; if (a_out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%b exp=0", a_out_valid); end
    total++; if (a_q !== 1'b0 || a_qbar !== 1'b1) begin bad++; $display("FAIL rst_q_qbar got=%b%b exp=01", a_q, a_qbar); end
    total++; if (a_in_ready !== 1'b0 || b_in_ready !== 1'b0) begin bad++; $display("FAIL rst_in_ready got=%b%b exp=00", a_in_ready, b_in_ready); end
    tick(); tick();
    total++; if (a_out_valid !== 1'b0 || a_first !== 1'b0 || a_last !== 1'b0 || a_busy !== 1'b0) begin bad++; $display("FAIL rst_clocked got=v%b f%b l%b b%b exp=0000", a_out_valid, a_first, a_last, a_busy); end
    a_in_valid = 1'b0; b_in_valid = 1'b0; c_in_valid = 1'b0;
    a_out_ready = 1'b1; b_out_ready = 1'b1; c_out_ready = 1'b1;
    #2 reset = 1'b1;
    #1;
    total++; if (a_in_ready !== 1'b1 || a_busy !== 1'b0) begin bad++; $display("FAIL rst_release got=rdy%b busy%b exp=rdy1 busy0", a_in_ready, a_busy); end
    tick();
  endtask

  task automatic test_basic_lsb();
    logic [7:0] exp_bits;
    exp_bits = 8'b1010_0101;  // bit i = beat i for 8'hA5 LSB first
    a_in_data = 8'hA5; a_in_valid = 1'b1; a_out_ready = 1'b1;
    total++; if (a_in_ready !== 1'b1) begin bad++; $display("FAIL basic_idle_ready got=%b exp=1", a_in_ready); end
    tick();
    a_in_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      total++;
      if (a_out_valid !== 1'b1 || a_q !== exp_bits[i] || a_qbar !== ~exp_bits[i] ||
          a_first !== (i == 0) || a_last !== (i == 7) || a_busy !== 1'b1 ||
          a_in_ready !== (i == 7)) begin
        bad++;
        $display("FAIL basic_beat%0d got=v%b q%b qb%b f%b l%b b%b r%b exp q=%b", i,
                 a_out_valid, a_q, a_qbar, a_first, a_last, a_busy, a_in_ready, exp_bits[i]);
      end
      tick();
    end
    total++; if (a_out_valid !== 1'b0 || a_busy !== 1'b0 || a_in_ready !== 1'b1) begin bad++; $display("FAIL basic_idle got=v%b b%b r%b exp=v0 b0 r1", a_out_valid, a_busy, a_in_ready); end
  endtask

  task automatic test_stall();
    logic [7:0] got;
    int beat;
    int cycles;
    got = '0; beat = 0; cycles = 0;
    a_in_data = 8'hA5; a_in_valid = 1'b1; a_out_ready = 1'b1;
    tick();
    a_in_valid = 1'b0;
    while (a_out_valid === 1'b1 && cycles < 40) begin
      a_out_ready = !(beat == 3 && cycles < 6);
      #1;
      if (beat == 3 && !a_out_ready) begin
        total++;
        if (a_q !== 1'b0 || a_qbar !== 1'b1 || a_first !== 1'b0 || a_last !== 1'b0 || a_in_ready !== 1'b0) begin
          bad++;
          $display("FAIL stall_hold cyc%0d got=q%b qb%b f%b l%b r%b exp=q0 qb1 f0 l0 r0", cycles, a_q, a_qbar, a_first, a_last, a_in_ready);
        end
      end
      if (a_out_ready) begin
        got[beat] = a_q;
        beat++;
      end
      tick();
      cycles++;
    end
    a_out_ready = 1'b1;
    total++; if (got !== 8'hA5 || beat != 8) begin bad++; $display("FAIL stall_data got=%h beats=%0d exp=a5 beats=8", got, beat); end
    total++; if (cycles != 11) begin bad++; $display("FAIL stall_cycles got=%0d exp=11", cycles); end
  endtask

  task automatic test_back_to_back();
    a_in_data = 8'hFF; a_in_valid = 1'b1; a_out_ready = 1'b1;
    tick();
    a_in_data = 8'h00;
    for (int i = 0; i < 16; i++) begin
      if (i == 8) a_in_valid = 1'b0;
      #1;
      total++;
      if (a_out_valid !== 1'b1 || a_q !== (i < 8) || a_first !== (i % 8 == 0) ||
          a_last !== (i % 8 == 7) || a_in_ready !== (i % 8 == 7)) begin
        bad++;
        $display("FAIL b2b_beat%0d got=v%b q%b f%b l%b r%b exp q=%b", i,
                 a_out_valid, a_q, a_first, a_last, a_in_ready, (i < 8));
      end
      tick();
    end
    total++; if (a_out_valid !== 1'b0 || a_busy !== 1'b0) begin bad++; $display("FAIL b2b_end got=v%b b%b exp=v0 b0", a_out_valid, a_busy); end
  endtask

  task automatic test_msb_first();
    logic [7:0] exp_a;
    logic [7:0] exp_b;
    exp_a = 8'b1000_0001;  // 8'h81: 1,0,0,0,0,0,0,1
    exp_b = 8'b0000_0001;  // 8'h80: 1 then seven 0s
    b_in_data = 8'h81; b_in_valid = 1'b1; b_out_ready = 1'b1;
    tick();
    b_in_data = 8'h80;
    for (int i = 0; i < 16; i++) begin
      if (i == 8) b_in_valid = 1'b0;
      #1;
      total++;
      if (b_out_valid !== 1'b1 || b_q !== ((i < 8) ? exp_a[i] : exp_b[i-8]) ||
          b_qbar === b_q || b_first !== (i % 8 == 0) || b_last !== (i % 8 == 7)) begin
        bad++;
        $display("FAIL msb_beat%0d got=v%b q%b qb%b f%b l%b", i, b_out_valid, b_q, b_qbar, b_first, b_last);
      end
      tick();
    end
    total++; if (b_out_valid !== 1'b0 || b_in_ready !== 1'b1) begin bad++; $display("FAIL msb_end got=v%b r%b exp=v0 r1", b_out_valid, b_in_ready); end
  endtask

  task automatic test_reset_mid_word();
    logic [7:0] exp_bits;
    exp_bits = 8'b0011_1100;  // 8'h3C LSB first: 0,0,1,1,1,1,0,0
    a_in_data = 8'hA5; a_in_valid = 1'b1; a_out_ready = 1'b1;
    tick();
    a_in_valid = 1'b0;
    repeat (4) tick();
    total++; if (a_q !== 1'b0 || a_out_valid !== 1'b1) begin bad++; $display("FAIL mid_beat4 got=v%b q%b exp=v1 q0", a_out_valid, a_q); end
    #2 reset = 1'b0;
    #1;
    total++;
    if (a_out_valid !== 1'b0 || a_q !== 1'b0 || a_qbar !== 1'b1 || a_busy !== 1'b0 ||
        a_in_ready !== 1'b0 || a_first !== 1'b0 || a_last !== 1'b0) begin
      bad++;
      $display("FAIL mid_reset got=v%b q%b qb%b b%b r%b f%b l%b", a_out_valid, a_q, a_qbar, a_busy, a_in_ready, a_first, a_last);
    end
    tick();
    #2 reset = 1'b1;
    #1;
    total++; if (a_in_ready !== 1'b1 || a_out_valid !== 1'b0) begin bad++; $display("FAIL mid_release got=r%b v%b exp=r1 v0", a_in_ready, a_out_valid); end
    tick();
    a_in_data = 8'h3C; a_in_valid = 1'b1;
    tick();
    a_in_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      total++;
      if (a_out_valid !== 1'b1 || a_q !== exp_bits[i] || a_first !== (i == 0) || a_last !== (i == 7)) begin
        bad++;
        $display("FAIL mid_reload_beat%0d got=v%b q%b f%b l%b exp q=%b", i, a_out_valid, a_q, a_first, a_last, exp_bits[i]);
      end
      tick();
    end
  endtask

  task automatic test_width1();
    c_in_data = 1'b1; c_in_valid = 1'b1; c_out_ready = 1'b1;
    tick();
    c_in_data = 1'b0;
    total++; if (c_out_valid !== 1'b1 || c_q !== 1'b1 || c_first !== 1'b1 || c_last !== 1'b1 || c_in_ready !== 1'b1) begin bad++; $display("FAIL w1_beat0 got=v%b q%b f%b l%b r%b exp=11111", c_out_valid, c_q, c_first, c_last, c_in_ready); end
    tick();
    c_in_valid = 1'b0;
    #1;
    total++; if (c_out_valid !== 1'b1 || c_q !== 1'b0 || c_qbar !== 1'b1 || c_first !== 1'b1 || c_last !== 1'b1) begin bad++; $display("FAIL w1_beat1 got=v%b q%b qb%b f%b l%b exp=v1 q0 qb1 f1 l1", c_out_valid, c_q, c_qbar, c_first, c_last); end
    tick();
    total++; if (c_out_valid !== 1'b0 || c_busy !== 1'b0) begin bad++; $display("FAIL w1_end got=v%b b%b exp=v0 b0", c_out_valid, c_busy); end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b0;
    a_in_valid = 1'b0; a_in_data = '0; a_out_ready = 1'b0;
    b_in_valid = 1'b0; b_in_data = '0; b_out_ready = 1'b0;
    c_in_valid = 1'b0; c_in_data = '0; c_out_ready = 1'b0;
    #12;
    test_reset();
    test_basic_lsb();
    tick();
    test_stall();
    tick();
    test_back_to_back();
    tick();
    test_msb_first();
    tick();
    test_reset_mid_word();
    tick();
    test_width1();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout reached before test completion");
    $fatal(1, "timeout");
  end

endmodule : tb_word_serializer

`default_nettype wire
